// File: rtl/rot_capture_pkg.sv
// Shared types and constants for the rotated stream capture block.
// Holds the capture FSM states, CRC-16/CCITT constants and the write FIFO entry layout.
package rot_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int ENTRY_AW = 17;
  localparam int ENTRY_DW = 8;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] data;
  } pix_entry_t;

  // MSB-first, unreflected CRC-16/CCITT update over one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/rot_pix_fifo.sv
// First-word-fall-through FIFO for {addr, data} pixel writes.
// A push while full is accepted only when a pop happens in the same cycle.
module rot_pix_fifo #(
  parameter int W = 25,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(N);

  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [N];
  logic         w_push_ok;
  logic         w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign pop_data  = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rotated_stream_capture.sv
// Captures the rotated video stream into linear-addressed memory writes via a FWFT FIFO.
// Define ROT_CAPTURE_CRC_EN to add the per-frame CRC-16/CCITT output frame_crc.
//
// state    | meaning
// IDLE     | after reset, waiting for a vsync gap; pixels ignored
// WAIT_SOF | in vsync gap, waiting for its falling edge to start a frame
// ACTIVE   | capturing pixels and tracking line/pixel coordinates
// DRAIN    | frame ended, waiting for the FIFO to empty before frame_done
module rotated_stream_capture
  import rot_capture_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LINE_PIX   = 240,
  parameter int LINES      = 320,
  parameter int AW         = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [AW-1:0]    mem_addr,
  output logic [DEPTH-1:0] mem_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             frame_done,
  output logic [15:0]      frame_lines,
  output logic             busy,
  output logic             err_line_len,
  output logic             err_geom,
  output logic             err_ovf,
  output logic [15:0]      drop_cnt,
`ifdef ROT_CAPTURE_CRC_EN
  output logic [15:0]      frame_crc,
`endif
  input  logic             err_clr
);

  localparam int EW = AW + DEPTH;

  state_t          r_state, w_state_nxt;
  logic            r_vsync_d, r_de_d;
  logic [15:0]     r_x, r_line_cnt;
  logic [AW-1:0]   r_row_base;
  logic            r_frame_done;
  logic [15:0]     r_frame_lines;
  logic            r_err_line_len, r_err_geom, r_err_ovf;
  logic [15:0]     r_drop_cnt;

  logic            w_vs_rise, w_vs_fall, w_line_end;
  logic            w_sof, w_done, w_overlap;
  logic            w_pix, w_in_range, w_push_req, w_push, w_pop, w_drop;
  logic            w_len_evt, w_geom_evt, w_ovf_evt;
  logic            w_full, w_empty;
  logic [AW-1:0]   w_addr;
  logic [EW-1:0]   w_head;
  logic            w_unused;

  assign w_unused  = hsync;  // line boundaries come from de alone
  assign w_vs_rise = vsync & ~r_vsync_d;
  assign w_vs_fall = ~vsync & r_vsync_d;
  assign w_line_end = (r_state == ACTIVE) & r_de_d & ~de;

  always_comb begin
    w_state_nxt = r_state;
    w_sof       = 1'b0;
    w_done      = 1'b0;
    w_overlap   = 1'b0;
    case (r_state)
      IDLE:     if (vsync) w_state_nxt = WAIT_SOF;
      WAIT_SOF: if (w_vs_fall) begin
                  w_state_nxt = ACTIVE;
                  w_sof       = 1'b1;
                end
      ACTIVE:   if (w_vs_rise) w_state_nxt = DRAIN;
      DRAIN:    if (w_vs_fall) begin
                  w_state_nxt = ACTIVE;
                  w_sof       = 1'b1;
                  w_done      = 1'b1;
                  w_overlap   = ~w_empty;
                end else if (w_empty) begin
                  w_state_nxt = WAIT_SOF;
                  w_done      = 1'b1;
                end
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_pix      = (r_state == ACTIVE) & de;
  assign w_in_range = (r_x < 16'(LINE_PIX)) & (r_line_cnt < 16'(LINES));
  assign w_push_req = w_pix & w_in_range;
  assign w_pop      = ~w_empty & mem_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_addr     = r_row_base + AW'(r_x);
  assign w_len_evt  = w_line_end & (r_x != 16'(LINE_PIX));
  assign w_geom_evt = w_pix & ~w_in_range;
  assign w_ovf_evt  = w_drop | w_overlap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_vsync_d <= 1'b0;
      r_de_d    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_d <= vsync;
      r_de_d    <= de;
    end
  end

  // Row base is a running sum so no multiplier is needed for line*LINE_PIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_line_cnt <= '0;
      r_row_base <= '0;
    end else if (w_sof) begin
      r_x        <= '0;
      r_line_cnt <= '0;
      r_row_base <= '0;
    end else if (r_state == ACTIVE) begin
      if (de) begin
        if (r_x != 16'hFFFF) r_x <= r_x + 16'd1;
      end else if (w_line_end) begin
        r_x        <= '0;
        r_row_base <= r_row_base + AW'(LINE_PIX);
        if (r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done   <= 1'b0;
      r_frame_lines  <= '0;
      r_err_line_len <= 1'b0;
      r_err_geom     <= 1'b0;
      r_err_ovf      <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      r_frame_done <= w_done;
      if (w_done) r_frame_lines <= r_line_cnt;
      r_err_line_len <= (r_err_line_len & ~err_clr) | w_len_evt;
      r_err_geom     <= (r_err_geom & ~err_clr) | w_geom_evt;
      r_err_ovf      <= (r_err_ovf & ~err_clr) | w_ovf_evt;
      if (err_clr)                             r_drop_cnt <= {15'd0, w_drop};
      else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  rot_pix_fifo #(
    .W (EW),
    .N (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({w_addr, video_in}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign mem_valid    = ~w_empty;
  assign mem_addr     = w_empty ? '0 : w_head[EW-1:DEPTH];
  assign mem_data     = w_empty ? '0 : w_head[DEPTH-1:0];
  assign frame_done   = r_frame_done;
  assign frame_lines  = r_frame_lines;
  assign busy         = (r_state == ACTIVE) | (r_state == DRAIN);
  assign err_line_len = r_err_line_len;
  assign err_geom     = r_err_geom;
  assign err_ovf      = r_err_ovf;
  assign drop_cnt     = r_drop_cnt;

`ifdef ROT_CAPTURE_CRC_EN
  logic [15:0] r_crc, r_frame_crc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc       <= CRC_INIT;
      r_frame_crc <= '0;
    end else begin
      if (w_sof)       r_crc <= CRC_INIT;
      else if (w_push) r_crc <= crc16_byte(r_crc, 8'(video_in));
      if (w_done) r_frame_crc <= r_crc;
    end
  end

  assign frame_crc = r_frame_crc;
`endif

endmodule

// File: tb/tb_rotated_stream_capture.sv
// Directed self-checking bench for rotated_stream_capture; honours ROT_CAPTURE_CRC_EN.
module tb_rotated_stream_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  video_in = '0;
  logic        hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic        mem_ready = 1'b1;
  logic        err_clr = 1'b0;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid, frame_done, busy;
  logic        err_line_len, err_geom, err_ovf;
  logic [15:0] frame_lines, drop_cnt;
`ifdef ROT_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
  logic [15:0] done_crc;
`endif

  int checks = 0;
  int errors = 0;
  int obs_addr[$];
  int obs_data[$];
  int done_cnt = 0;
  logic [15:0] done_lines;

  rotated_stream_capture dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .video_in     (video_in),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .frame_done   (frame_done),
    .frame_lines  (frame_lines),
    .busy         (busy),
    .err_line_len (err_line_len),
    .err_geom     (err_geom),
    .err_ovf      (err_ovf),
    .drop_cnt     (drop_cnt),
`ifdef ROT_CAPTURE_CRC_EN
    .frame_crc    (frame_crc),
`endif
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && mem_valid && mem_ready) begin
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(int'(mem_data));
    end
    if (reset_n && frame_done) begin
      done_cnt++;
      done_lines = frame_lines;
`ifdef ROT_CAPTURE_CRC_EN
      done_crc = frame_crc;
`endif
    end
  end

  function automatic logic [7:0] pix(input int l, input int x);
    int v;
    v = l * 3 + x * 5;
    return v[7:0];
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input int dl);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      video_in = pix(dl, i);
      tick();
    end
    de = 1'b0;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == prev) begin
      errors++;
      $display("FAIL %s frame_done timeout: got no pulse within %0d cycles, want one", name, budget);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({mem_valid, frame_done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got valid/done/busy %b, want 000", {mem_valid, frame_done, busy});
    end
    checks++;
    if (mem_addr !== 17'd0 || mem_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr %0d data %0h, want 0 0", mem_addr, mem_data);
    end
    checks++;
    if ({err_line_len, err_geom, err_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: got %b, want 000", {err_line_len, err_geom, err_ovf});
    end
    checks++;
    if (frame_lines !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got lines %0d drops %0d, want 0 0", frame_lines, drop_cnt);
    end
  endtask

  task automatic test_nominal();
    int prev = done_cnt;
    int bad = -1;
    logic [15:0] crc = 16'hFFFF;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nom_busy: got %b, want 1", busy);
    end
    for (int l = 0; l < 320; l++) send_line(240, l);
    end_frame();
    wait_done(prev, 200, "nominal");
    repeat (5) tick();
    checks++;
    if (obs_addr.size() != 76800) begin
      errors++;
      $display("FAIL nom_count: got %0d writes, want 76800", obs_addr.size());
    end
    for (int i = 0; i < 76800 && i < obs_addr.size(); i++) begin
      crc = crc_upd(crc, pix(i / 240, i % 240));
      if (bad < 0 && (obs_addr[i] != i || obs_data[i] != int'(pix(i / 240, i % 240)))) bad = i;
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL nom_seq: got addr %0d data %0h at index %0d, want addr %0d data %0h",
               obs_addr[bad], obs_data[bad], bad, bad, pix(bad / 240, bad % 240));
    end
    checks++;
    if (done_cnt != prev + 1) begin
      errors++;
      $display("FAIL nom_done_cnt: got %0d pulses, want 1", done_cnt - prev);
    end
    checks++;
    if (done_lines !== 16'd320) begin
      errors++;
      $display("FAIL nom_lines: got %0d, want 320", done_lines);
    end
    checks++;
    if ({err_line_len, err_geom, err_ovf, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL nom_flags: got len/geom/ovf/busy %b, want 0000", {err_line_len, err_geom, err_ovf, busy});
    end
`ifdef ROT_CAPTURE_CRC_EN
    checks++;
    if (done_crc !== crc) begin
      errors++;
      $display("FAIL nom_crc: got %04h, want %04h", done_crc, crc);
    end
`endif
  endtask

  task automatic test_stall();
    int prev = done_cnt;
    int bad = -1;
    bit stable = 1'b1;
    logic [15:0] crc = 16'hFFFF;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      de = 1'b1;
      video_in = pix(0, i);
      tick();
      if (mem_valid !== 1'b1 || mem_addr !== 17'd0 || mem_data !== pix(0, 0)) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall_stable: got addr %0d data %0h valid %b, want 0 %0h 1", mem_addr, mem_data, mem_valid, pix(0, 0));
    end
    checks++;
    if (err_ovf !== 1'b1 || drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stall_drop: got ovf %b drops %0d, want 1 4", err_ovf, drop_cnt);
    end
    mem_ready = 1'b1;
    for (int i = 20; i < 240; i++) begin
      de = 1'b1;
      video_in = pix(0, i);
      tick();
    end
    de = 1'b0;
    tick();
    end_frame();
    wait_done(prev, 200, "stall");
    checks++;
    if (obs_addr.size() != 236) begin
      errors++;
      $display("FAIL stall_count: got %0d writes, want 236", obs_addr.size());
    end
    for (int j = 0; j < 236 && j < obs_addr.size(); j++) begin
      int x;
      x = (j < 16) ? j : j + 4;
      crc = crc_upd(crc, pix(0, x));
      if (bad < 0 && (obs_addr[j] != x || obs_data[j] != int'(pix(0, x)))) bad = j;
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL stall_order: got addr %0d at index %0d, want %0d", obs_addr[bad], bad, (bad < 16) ? bad : bad + 4);
    end
    checks++;
    if ({err_line_len, err_geom} !== 2'b00 || done_lines !== 16'd1) begin
      errors++;
      $display("FAIL stall_misc: got len/geom %b lines %0d, want 00 1", {err_line_len, err_geom}, done_lines);
    end
`ifdef ROT_CAPTURE_CRC_EN
    checks++;
    if (done_crc !== crc) begin
      errors++;
      $display("FAIL stall_crc: got %04h, want %04h", done_crc, crc);
    end
`endif
    pulse_clr();
    checks++;
    if (err_ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_clr: got ovf %b drops %0d, want 0 0", err_ovf, drop_cnt);
    end
  endtask

  task automatic test_line_len();
    int prev = done_cnt;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    for (int l = 0; l < 7; l++) begin
      send_line((l == 5) ? 239 : 240, l);
      if (l == 4) begin
        checks++;
        if (err_line_len !== 1'b0) begin
          errors++;
          $display("FAIL len_before: got %b, want 0", err_line_len);
        end
      end
      if (l == 5) begin
        checks++;
        if (err_line_len !== 1'b1) begin
          errors++;
          $display("FAIL len_short: got %b, want 1", err_line_len);
        end
      end
    end
    end_frame();
    wait_done(prev, 200, "line_len");
    checks++;
    if (obs_addr.size() != 1679) begin
      errors++;
      $display("FAIL len_count: got %0d writes, want 1679", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[1438] != 1438 || obs_addr[1439] != 1440 || obs_data[1439] != int'(pix(6, 0))) begin
        errors++;
        $display("FAIL len_line6: got addr %0d/%0d data %0h, want 1438/1440 %0h",
                 obs_addr[1438], obs_addr[1439], obs_data[1439], pix(6, 0));
      end
    end
    checks++;
    if (err_geom !== 1'b0 || done_lines !== 16'd7) begin
      errors++;
      $display("FAIL len_misc: got geom %b lines %0d, want 0 7", err_geom, done_lines);
    end
    pulse_clr();
  endtask

  task automatic test_x_overflow();
    int prev = done_cnt;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    send_line(241, 1);
    checks++;
    if ({err_geom, err_line_len} !== 2'b11) begin
      errors++;
      $display("FAIL xovf_flags: got geom/len %b, want 11", {err_geom, err_line_len});
    end
    end_frame();
    wait_done(prev, 200, "x_overflow");
    checks++;
    if (obs_addr.size() != 240 || obs_addr[obs_addr.size() - 1] != 239) begin
      errors++;
      $display("FAIL xovf_writes: got %0d writes, want 240 ending at 239", obs_addr.size());
    end
    pulse_clr();
    checks++;
    if ({err_line_len, err_geom, err_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL xovf_clr: got %b, want 000", {err_line_len, err_geom, err_ovf});
    end
  endtask

  task automatic test_geom();
    int prev = done_cnt;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    for (int l = 0; l < 320; l++) send_line(2, l);
    checks++;
    if (err_geom !== 1'b0) begin
      errors++;
      $display("FAIL geom_in_range: got %b, want 0", err_geom);
    end
    de = 1'b1;
    video_in = 8'h5A;
    tick();
    checks++;
    if (err_geom !== 1'b1) begin
      errors++;
      $display("FAIL geom_line320: got %b, want 1", err_geom);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_geom !== 1'b1 || err_line_len !== 1'b0) begin
      errors++;
      $display("FAIL geom_clr_race: got geom %b len %b, want 1 0", err_geom, err_line_len);
    end
    de = 1'b0;
    tick();
    end_frame();
    wait_done(prev, 200, "geom");
    checks++;
    if (done_lines !== 16'd321 || obs_addr.size() != 640) begin
      errors++;
      $display("FAIL geom_lines: got lines %0d writes %0d, want 321 640", done_lines, obs_addr.size());
    end
    pulse_clr();
    checks++;
    if ({err_line_len, err_geom, err_ovf} !== 3'b000 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL geom_clr: got %b drops %0d, want 000 0", {err_line_len, err_geom, err_ovf}, drop_cnt);
    end
  endtask

  task automatic test_drain_overlap();
    int prev = done_cnt;
    int bad = -1;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    mem_ready = 1'b0;
    send_line(8, 0);
    end_frame();
    tick();
    checks++;
    if (busy !== 1'b1 || done_cnt != prev) begin
      errors++;
      $display("FAIL ovl_drain: got busy %b pulses %0d, want 1 0", busy, done_cnt - prev);
    end
    vsync = 1'b0;
    tick();
    checks++;
    if ({frame_done, err_ovf, busy} !== 3'b111 || frame_lines !== 16'd1) begin
      errors++;
      $display("FAIL ovl_restart: got done/ovf/busy %b lines %0d, want 111 1", {frame_done, err_ovf, busy}, frame_lines);
    end
    send_line(4, 9);
    mem_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (obs_addr.size() != 12) begin
      errors++;
      $display("FAIL ovl_count: got %0d writes, want 12", obs_addr.size());
    end
    for (int j = 0; j < 12 && j < obs_addr.size(); j++) begin
      int ea, ed;
      ea = (j < 8) ? j : j - 8;
      ed = (j < 8) ? int'(pix(0, j)) : int'(pix(9, j - 8));
      if (bad < 0 && (obs_addr[j] != ea || obs_data[j] != ed)) bad = j;
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL ovl_order: got addr %0d data %0h at index %0d, want old frame first", obs_addr[bad], obs_data[bad], bad);
    end
    end_frame();
    wait_done(prev + 1, 200, "overlap");
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    int prev;
    int n_at_reset;
    obs_addr.delete();
    obs_data.delete();
    start_frame();
    send_line(240, 0);
    for (int i = 0; i < 100; i++) begin
      de = 1'b1;
      video_in = pix(1, i);
      tick();
    end
    reset_n = 1'b0;
    n_at_reset = obs_addr.size();
    #1;
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid: got valid %b busy %b, want 0 0", mem_valid, busy);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 103; i < 240; i++) begin
      video_in = pix(1, i);
      tick();
    end
    de = 1'b0;
    tick();
    send_line(240, 2);
    checks++;
    if (obs_addr.size() != n_at_reset || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ignore: got %0d writes busy %b, want 0 0", obs_addr.size() - n_at_reset, busy);
    end
    prev = done_cnt;
    start_frame();
    send_line(4, 3);
    end_frame();
    wait_done(prev, 200, "reset_mid");
    checks++;
    if (obs_addr.size() != n_at_reset + 4 || obs_addr[n_at_reset] != 0 || done_lines !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_next: got %0d writes first addr %0d lines %0d, want 4 0 1",
               obs_addr.size() - n_at_reset, (obs_addr.size() > n_at_reset) ? obs_addr[n_at_reset] : -1, done_lines);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_line_len();
    test_x_overflow();
    test_geom();
    test_drain_overlap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion by 3ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rotated_stream_capture.md
Name: rotated_stream_capture

Overview:
- Receiving end of the rotated video stream: consumes the pixel stream qualified by de/hsync/vsync, where each input line is one source column (LINE_PIX pixels) and there are LINES lines per frame.
- Reconstructs pixel/line coordinates and emits linear-addressed pixel writes over a valid/ready memory interface, buffered through a small FIFO.
- Reports frame completion, geometry errors and drop statistics to the downstream scaler/frame-store control.

Parameters:
DEPTH, 8, pixel width in bits
LINE_PIX, 240, pixels per input line
LINES, 320, lines per frame
AW, 17, memory address width; must satisfy LINE_PIX*LINES <= 2**AW
FIFO_DEPTH, 16, write FIFO entries (power of two, >=4)

Ports:
clk  in  1  single clock for stream and memory side
reset_n  in  1  asynchronous active-low reset
video_in  in  DEPTH  pixel data, valid when de=1
hsync  in  1  line gap indicator, high between lines
vsync  in  1  frame gap indicator, high between frames
de  in  1  pixel valid; one pixel per clk while high
mem_addr  out  AW  write address = line*LINE_PIX + pixel
mem_data  out  DEPTH  write data
mem_valid  out  1  write request
mem_ready  in  1  sink accepts when mem_valid & mem_ready
frame_done  out  1  one-cycle pulse at end of drained frame
frame_lines  out  16  lines seen in last completed frame (saturating)
busy  out  1  high in ACTIVE or DRAIN
err_line_len  out  1  sticky: a line ended with pixel count != LINE_PIX
err_geom  out  1  sticky: pixel beyond LINE_PIX or LINES
err_ovf  out  1  sticky: pixel dropped, FIFO full
drop_cnt  out  16  saturating count of FIFO-full drops
err_clr  in  1  clears all sticky errors and drop_cnt

Behaviour:
- Reset (async, immediate): state IDLE, FIFO empty, mem_valid=0, mem_addr=0, mem_data=0, frame_done=0, frame_lines=0, busy=0, all errors=0, drop_cnt=0.
- States:
  - IDLE: wait for vsync=1 → WAIT_SOF. Pixels arriving in IDLE are ignored, so a partial frame after reset is never written.
  - WAIT_SOF: vsync falling edge → ACTIVE; clear x, y, row base and line counter.
  - ACTIVE: capture pixels. vsync rising edge → DRAIN.
  - DRAIN: when FIFO empty, pulse frame_done, latch frame_lines → WAIT_SOF.
- Coordinates: x counts de pixels in the current line. Line end = de falling edge.
- At line end:
  - if x != LINE_PIX, set err_line_len;
  - y increments; row base += LINE_PIX (running adder, no multiplier); x=0.
  - Lines with zero pixels are not counted.
- Address: row base + x. Write pushed on a de cycle only if x < LINE_PIX and y < LINES; otherwise dropped and err_geom set.
- FIFO holds {addr, data}, in order.
  - Push and pop in the same cycle is legal when full.
  - Push to a full FIFO without a simultaneous pop: pixel dropped, err_ovf set, drop_cnt += 1 (saturating at 0xFFFF).
- Memory handshake:
  - mem_valid = FIFO not empty, driven from the FIFO head (first-word-fall-through).
  - mem_addr and mem_data are stable while mem_valid=1 and mem_ready=0.
  - Pop on mem_valid & mem_ready.
  - Latency from de pixel to mem_valid is 1 cycle when the FIFO is empty.
- vsync falling edge during DRAIN (next frame begins before drain completes):
  - pulse frame_done and latch frame_lines that cycle;
  - set err_ovf;
  - enter ACTIVE with coordinates cleared.
  - Old-frame FIFO entries are still delivered ahead of new ones.
- err_clr coinciding with a new error event: the error event wins and its flag remains set. drop_cnt is cleared then incremented, so it reads 1.
- busy = state ACTIVE or DRAIN.

Optional Feature:
- Macro ROT_CAPTURE_CRC_EN.
- With macro defined:
  - Adds output frame_crc[15:0], CRC-16/CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over the low 8 bits of every accepted pixel (pushed, not dropped) in arrival order.
  - CRC is reset at start of ACTIVE and latched to frame_crc on the frame_done pulse.
  - frame_crc resets to 0.
- Without macro: the port and all CRC logic are absent.

Decomposition:
- Shared package rot_capture_pkg holds:
  - state enum (IDLE, WAIT_SOF, ACTIVE, DRAIN);
  - CRC polynomial/init constants;
  - the {addr, data} FIFO entry typedef, parameterised by AW/DEPTH via localparam widths.
- One sub-module, rot_pix_fifo: synchronous first-word-fall-through FIFO with full/empty, async active-low reset, and simultaneous push/pop when full.

Test Plan:
- Nominal 240x320 frame, mem_ready=1 → 76800 writes, addresses 0..76799 strictly increasing, one frame_done, frame_lines=320, all errors 0.
- mem_ready held low for 20 consecutive pixel cycles mid-line with FIFO empty → 16 entries buffered, 4 pixels dropped, err_ovf=1, drop_cnt=4. After mem_ready=1, the 16 entries are delivered in order with stable addr/data while stalled.
- Line 5 has 239 pixels → err_line_len=1. Line 6 first write address = 1440, no err_geom.
- Frame of 321 lines → line 320 pixels dropped, err_geom=1, frame_lines=321. err_clr pulse → flags 0. err_clr in the same cycle as a geometry drop → err_geom stays 1.
- reset_n asserted mid-frame for 3 cycles, released mid-line → mem_valid drops immediately, no writes until after the next vsync falling edge. The following frame begins at address 0.
- With ROT_CAPTURE_CRC_EN, single 240x320 frame with all pixels 0x00 → frame_crc equals the CRC-16/CCITT model over 76800 zero bytes, valid on the frame_done cycle. Without the macro, the build has no frame_crc port.
